// File: rtl/hsv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hsv_pkg                                                         |
// | Purpose  : Shared constants, converter state type and hue wrap helper for  |
// |            the HSV mode engine.                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package hsv_pkg;

   // Mode codes produced by the button mode selector
   localparam logic [3:0] MODE_HUE_INIT  = 4'd0;
   localparam logic [3:0] MODE_HUE_ADD60 = 4'd1;
   localparam logic [3:0] MODE_HUE_STEP  = 4'd2;
   localparam logic [3:0] MODE_HUE_SET   = 4'd3;
   localparam logic [3:0] MODE_SAT_SET   = 4'd4;
   localparam logic [3:0] MODE_VAL_SET   = 4'd5;
   localparam logic [3:0] MODE_SV_HALF   = 4'd6;

   localparam logic [8:0]  HUE_MAX  = 9'd359;
   localparam logic [6:0]  PCT_MAX  = 7'd100;
   localparam logic [6:0]  PCT_HALF = 7'd50;
   localparam logic [7:0]  SCALE_8B = 8'd255;
   localparam logic [12:0] SCALE_QT = 13'd6000;   // 60 (degrees/sector) * 100 (percent)

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SECTOR = 3'd1,
      ST_MUL    = 3'd2,
      ST_DIV_VM = 3'd3,
      ST_DIV_P  = 3'd4,
      ST_DIV_Q  = 3'd5,
      ST_DIV_T  = 3'd6,
      ST_OUT    = 3'd7
   } conv_state_t;

   // (h + inc) mod 360, valid for h <= 359 and inc <= 60
   function automatic logic [8:0] hue_add(input logic [8:0] h, input logic [8:0] inc);
      logic [9:0] sum;
      sum = {1'b0, h} + {1'b0, inc};
      if (sum > {1'b0, HUE_MAX})
         return 9'(sum - 10'd360);
      return 9'(sum);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hsv_mode_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hsv_mode_engine_if                                              |
// | Purpose  : Bundles the mode engine's user-facing signals.                  |
// |            master : drives mode, h_in, s_in, v_in; observes the results.   |
// |            slave  : the engine; drives hue/sat/val, rgb_*, conv_done, pwm. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface hsv_mode_engine_if;
   logic [3:0] mode;
   logic [8:0] h_in;
   logic [6:0] s_in;
   logic [6:0] v_in;
   logic [8:0] hue;
   logic [6:0] sat;
   logic [6:0] val;
   logic [7:0] rgb_r;
   logic [7:0] rgb_g;
   logic [7:0] rgb_b;
   logic       conv_done;
   logic       pwm_r;
   logic       pwm_g;
   logic       pwm_b;

   modport master (
      output mode, h_in, s_in, v_in,
      input  hue, sat, val, rgb_r, rgb_g, rgb_b, conv_done, pwm_r, pwm_g, pwm_b
   );

   modport slave (
      input  mode, h_in, s_in, v_in,
      output hue, sat, val, rgb_r, rgb_g, rgb_b, conv_done, pwm_r, pwm_g, pwm_b
   );
endinterface
`default_nettype wire

// File: rtl/hsv2rgb_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hsv2rgb_seq                                                     |
// | Purpose  : Multi-cycle HSV -> RGB888 converter built around one shared     |
// |            restoring divider (quotient always fits in 8 bits).             |
// | Ports    : clk, reset          - clock, synchronous active-high reset      |
// |            start, h, s, v      - start pulse and operands (latched)        |
// |            busy                - conversion in progress                    |
// |            done, r, g, b       - one-cycle pulse with updated colour       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hsv2rgb_seq
   import hsv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [8:0] h,
   input  logic [6:0] s,
   input  logic [6:0] v,
   output logic       busy,
   output logic       done,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b
);

   conv_state_t state_q, state_d;
   logic [6:0]  s_q, s_d, v_q, v_d;
   logic [2:0]  sec_q, sec_d;
   logic [5:0]  f_q, f_d;
   logic [6:0]  kp_q, kp_d;             // 100 - s
   logic [12:0] kq_q, kq_d, kt_q, kt_d; // 6000 - s*f, 6000 - s*(60-f)
   logic [20:0] num_q, num_d;           // dividend / running remainder
   logic [12:0] den_q, den_d;
   logic [7:0]  quo_q, quo_d;
   logic [2:0]  bit_q, bit_d;           // quotient bit under trial
   logic [7:0]  vm_q, vm_d, p_q, p_d, q_q, q_d, t_q, t_d;
   logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic        done_q, done_d;

   // One restoring-division step: try subtracting den << bit
   logic [20:0] trial, num_step;
   logic [7:0]  quo_step;
   logic        fits, last;
   logic [12:0] sf, sg;

   always_comb begin
      trial    = 21'(den_q) << bit_q;
      fits     = (num_q >= trial);
      num_step = fits ? (num_q - trial) : num_q;
      quo_step = fits ? (quo_q | (8'd1 << bit_q)) : quo_q;
      last     = (bit_q == 3'd0);
      sf       = 13'(s_q) * 13'(f_q);
      sg       = 13'(s_q) * 13'(7'd60 - {1'b0, f_q});
   end

   always_comb begin
      state_d = state_q;
      s_d = s_q;  v_d = v_q;  sec_d = sec_q;  f_d = f_q;
      kp_d = kp_q;  kq_d = kq_q;  kt_d = kt_q;
      num_d = num_q;  den_d = den_q;  quo_d = quo_q;  bit_d = bit_q;
      vm_d = vm_q;  p_d = p_q;  q_d = q_q;  t_d = t_q;
      r_d = r_q;  g_d = g_q;  b_d = b_q;
      done_d = 1'b0;

      if (state_q inside {ST_SECTOR, ST_DIV_VM, ST_DIV_P, ST_DIV_Q, ST_DIV_T}) begin
         num_d = num_step;
         quo_d = quo_step;
         bit_d = bit_q - 3'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               s_d     = s;
               v_d     = v;
               num_d   = 21'(h);
               den_d   = 13'd60;
               quo_d   = '0;
               bit_d   = 3'd2;            // h <= 359 < 60*8
               state_d = ST_SECTOR;
            end
         end
         ST_SECTOR: begin
            if (last) begin
               sec_d   = quo_step[2:0];
               f_d     = num_step[5:0];
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            kp_d    = PCT_MAX - s_q;
            kq_d    = SCALE_QT - sf;
            kt_d    = SCALE_QT - sg;
            num_d   = 21'(v_q) * 21'(SCALE_8B);
            den_d   = 13'(PCT_MAX);
            quo_d   = '0;
            bit_d   = 3'd7;
            state_d = ST_DIV_VM;
         end
         ST_DIV_VM: begin
            if (last) begin
               vm_d    = quo_step;
               num_d   = 21'(quo_step) * 21'(kp_q);
               den_d   = 13'(PCT_MAX);
               quo_d   = '0;
               bit_d   = 3'd7;
               state_d = ST_DIV_P;
            end
         end
         ST_DIV_P: begin
            if (last) begin
               p_d     = quo_step;
               num_d   = 21'(vm_q) * 21'(kq_q);
               den_d   = SCALE_QT;
               quo_d   = '0;
               bit_d   = 3'd7;
               state_d = ST_DIV_Q;
            end
         end
         ST_DIV_Q: begin
            if (last) begin
               q_d     = quo_step;
               num_d   = 21'(vm_q) * 21'(kt_q);
               den_d   = SCALE_QT;
               quo_d   = '0;
               bit_d   = 3'd7;
               state_d = ST_DIV_T;
            end
         end
         ST_DIV_T: begin
            if (last) begin
               t_d     = quo_step;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            // All three channels and done are registered together
            case (sec_q)
               3'd0:    begin r_d = vm_q; g_d = t_q;  b_d = p_q;  end
               3'd1:    begin r_d = q_q;  g_d = vm_q; b_d = p_q;  end
               3'd2:    begin r_d = p_q;  g_d = vm_q; b_d = t_q;  end
               3'd3:    begin r_d = p_q;  g_d = q_q;  b_d = vm_q; end
               3'd4:    begin r_d = t_q;  g_d = p_q;  b_d = vm_q; end
               default: begin r_d = vm_q; g_d = p_q;  b_d = q_q;  end
            endcase
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         s_q <= '0;  v_q <= '0;  sec_q <= '0;  f_q <= '0;
         kp_q <= '0;  kq_q <= '0;  kt_q <= '0;
         num_q <= '0;  den_q <= '0;  quo_q <= '0;  bit_q <= '0;
         vm_q <= '0;  p_q <= '0;  q_q <= '0;  t_q <= '0;
         r_q <= '0;  g_q <= '0;  b_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q <= s_d;  v_q <= v_d;  sec_q <= sec_d;  f_q <= f_d;
         kp_q <= kp_d;  kq_q <= kq_d;  kt_q <= kt_d;
         num_q <= num_d;  den_q <= den_d;  quo_q <= quo_d;  bit_q <= bit_d;
         vm_q <= vm_d;  p_q <= p_d;  q_q <= q_d;  t_q <= t_d;
         r_q <= r_d;  g_q <= g_d;  b_q <= b_d;
         done_q <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign r    = r_q;
   assign g    = g_q;
   assign b    = b_q;

endmodule
`default_nettype wire

// File: rtl/hsv_mode_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hsv_mode_engine                                                 |
// | Purpose  : Applies mode actions to the H/S/V registers, requests HSV->RGB  |
// |            conversions on any change and drives three 8-bit PWM outputs.   |
// | Ports    : clk, reset - clock, synchronous active-high reset               |
// |            bus        - slave side: mode/h_in/s_in/v_in in; hue/sat/val,   |
// |                         rgb_*, conv_done, pwm_* out                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hsv_mode_engine
   import hsv_pkg::*;
#(
   parameter int unsigned STEP_DIV = 4194304,
   parameter logic [8:0]  H_RESET  = 9'd120
)(
   input  logic             clk,
   input  logic             reset,
   hsv_mode_engine_if.slave bus
);

   localparam int unsigned         STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

   logic [8:0]        hue_q, hue_d, hue_prev_q;
   logic [6:0]        sat_q, sat_d, sat_prev_q;
   logic [6:0]        val_q, val_d, val_prev_q;
   logic [3:0]        mode_prev_q;
   logic [STEP_W-1:0] step_q, step_d;
   logic              first_q;              // forces a conversion right after reset
   logic              pend_q, pend_d;
   logic [7:0]        pcnt_q, duty_r_q, duty_g_q, duty_b_q;
   logic [7:0]        duty_r_d, duty_g_d, duty_b_d;

   logic              entry, req, start;
   logic              conv_busy, conv_done;
   logic [7:0]        conv_r, conv_g, conv_b;

   hsv2rgb_seq u_conv (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .h     (hue_q),
      .s     (sat_q),
      .v     (val_q),
      .busy  (conv_busy),
      .done  (conv_done),
      .r     (conv_r),
      .g     (conv_g),
      .b     (conv_b)
   );

   always_comb begin
      entry  = (bus.mode != mode_prev_q);
      hue_d  = hue_q;
      sat_d  = sat_q;
      val_d  = val_q;
      step_d = '0;

      case (bus.mode)
         MODE_HUE_INIT:  if (entry) hue_d = H_RESET;
         MODE_HUE_ADD60: if (entry) hue_d = hue_add(hue_q, 9'd60);
         MODE_HUE_STEP: begin
            // The entry cycle only clears the counter; stepping starts after it
            if (!entry) begin
               if (step_q == STEP_LAST)
                  hue_d = hue_add(hue_q, 9'd1);
               else
                  step_d = step_q + STEP_W'(1);
            end
         end
         MODE_HUE_SET:   hue_d = (bus.h_in > HUE_MAX) ? HUE_MAX : bus.h_in;
         MODE_SAT_SET:   sat_d = (bus.s_in > PCT_MAX) ? PCT_MAX : bus.s_in;
         MODE_VAL_SET:   val_d = (bus.v_in > PCT_MAX) ? PCT_MAX : bus.v_in;
         MODE_SV_HALF: begin
            if (entry) begin
               sat_d = PCT_HALF;
               val_d = PCT_HALF;
            end
         end
         default: ;
      endcase

      // A request while busy is folded into a single pending conversion,
      // which starts from the then-current H/S/V once the converter is idle.
      req    = first_q | (hue_q != hue_prev_q) | (sat_q != sat_prev_q) | (val_q != val_prev_q);
      start  = !conv_busy && (req || pend_q);
      pend_d = conv_busy && (req || pend_q);

      // Duty only reloads at the end of a PWM period
      duty_r_d = duty_r_q;
      duty_g_d = duty_g_q;
      duty_b_d = duty_b_q;
      if (pcnt_q == 8'hFF) begin
         duty_r_d = conv_r;
         duty_g_d = conv_g;
         duty_b_d = conv_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hue_q       <= H_RESET;
         sat_q       <= PCT_MAX;
         val_q       <= PCT_MAX;
         hue_prev_q  <= H_RESET;
         sat_prev_q  <= PCT_MAX;
         val_prev_q  <= PCT_MAX;
         mode_prev_q <= '0;
         step_q      <= '0;
         first_q     <= 1'b1;
         pend_q      <= 1'b0;
         pcnt_q      <= '0;
         duty_r_q    <= '0;
         duty_g_q    <= '0;
         duty_b_q    <= '0;
      end else begin
         hue_q       <= hue_d;
         sat_q       <= sat_d;
         val_q       <= val_d;
         hue_prev_q  <= hue_q;
         sat_prev_q  <= sat_q;
         val_prev_q  <= val_q;
         mode_prev_q <= bus.mode;
         step_q      <= step_d;
         first_q     <= 1'b0;
         pend_q      <= pend_d;
         pcnt_q      <= pcnt_q + 8'd1;
         duty_r_q    <= duty_r_d;
         duty_g_q    <= duty_g_d;
         duty_b_q    <= duty_b_d;
      end
   end

   assign bus.hue       = hue_q;
   assign bus.sat       = sat_q;
   assign bus.val       = val_q;
   assign bus.rgb_r     = conv_r;
   assign bus.rgb_g     = conv_g;
   assign bus.rgb_b     = conv_b;
   assign bus.conv_done = conv_done;
   assign bus.pwm_r     = (pcnt_q < duty_r_q);
   assign bus.pwm_g     = (pcnt_q < duty_g_q);
   assign bus.pwm_b     = (pcnt_q < duty_b_q);

endmodule
`default_nettype wire
